// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - FU result, flush and ROB finish signals of the completion bus
interface cdb_arbiter_if #(
  parameter int NUM_FU = 4,
  parameter int WIDTH  = 32
);
  logic [NUM_FU-1:0]       fu_valid;
  logic [NUM_FU*WIDTH-1:0] fu_tag;
  logic [NUM_FU*WIDTH-1:0] fu_val;
  logic [NUM_FU-1:0]       fu_ready;
  logic                    flushing_instr;
  logic [WIDTH-1:0]        instr_to_flush;
  logic                    finishing_instr;
  logic [WIDTH-1:0]        instr_to_finish;
  logic [WIDTH-1:0]        finish_val;
  logic                    busy;

  modport master (
    output fu_valid, fu_tag, fu_val, flushing_instr, instr_to_flush,
    input  fu_ready, finishing_instr, instr_to_finish, finish_val, busy
  );

  modport slave (
    input  fu_valid, fu_tag, fu_val, flushing_instr, instr_to_flush,
    output fu_ready, finishing_instr, instr_to_finish, finish_val, busy
  );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin completion-bus arbiter with per-FU hold entries and flush
module cdb_arbiter #(
  parameter int NUM_FU = 4,
  parameter int WIDTH  = 32
) (
  input  logic          clock,
  input  logic          reset,
  cdb_arbiter_if.slave  bus
);
  localparam int PW = $clog2(NUM_FU);

  logic [NUM_FU-1:0] hv;
  logic [WIDTH-1:0]  ht [NUM_FU];
  logic [WIDTH-1:0]  hd [NUM_FU];
  logic [PW-1:0]     rr_ptr;

  logic [NUM_FU-1:0] fm;
  logic [NUM_FU-1:0] in_kill;
  logic [NUM_FU-1:0] el;
  logic [NUM_FU-1:0] grant;
  logic [PW-1:0]     gidx;
  logic              gfound;
  int                idx;

  logic              fin_q;
  logic [WIDTH-1:0]  tag_q;
  logic [WIDTH-1:0]  val_q;

  // Flush kills both a held entry and a result arriving in the same cycle.
  always_comb begin
    fm      = '0;
    in_kill = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      fm[i]      = bus.flushing_instr & hv[i] & (ht[i] == bus.instr_to_flush);
      in_kill[i] = bus.flushing_instr &
                   (bus.fu_tag[i*WIDTH +: WIDTH] == bus.instr_to_flush);
    end
  end

  assign el = hv & ~fm;

  always_comb begin
    grant  = '0;
    gidx   = '0;
    gfound = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_FU;
      if (!gfound && el[idx]) begin
        gfound     = 1'b1;
        grant[idx] = 1'b1;
        gidx       = PW'(idx);
      end
    end
  end

  // An entry leaving this cycle (granted or flushed) frees its slot for a same-edge refill.
  assign bus.fu_ready        = ~hv | grant | fm;
  assign bus.busy            = |hv;
  assign bus.finishing_instr = fin_q;
  assign bus.instr_to_finish = tag_q;
  assign bus.finish_val      = val_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hv     <= '0;
      rr_ptr <= '0;
      fin_q  <= 1'b0;
      tag_q  <= '0;
      val_q  <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        ht[i] <= '0;
        hd[i] <= '0;
      end
    end else begin
      if (gfound) begin
        fin_q <= 1'b1;
        tag_q <= ht[gidx];
        val_q <= hd[gidx];
        if (gidx == PW'(NUM_FU - 1)) rr_ptr <= '0;
        else                         rr_ptr <= gidx + PW'(1);
      end else begin
        fin_q <= 1'b0;
      end
      for (int i = 0; i < NUM_FU; i++) begin
        if (bus.fu_valid[i] && bus.fu_ready[i]) begin
          hv[i] <= ~in_kill[i];
          ht[i] <= bus.fu_tag[i*WIDTH +: WIDTH];
          hd[i] <= bus.fu_val[i*WIDTH +: WIDTH];
        end else if (grant[i] || fm[i]) begin
          hv[i] <= 1'b0;
        end
      end
    end
  end
endmodule
